// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 UART: status bit positions, FSM encodings, frame width.
package uart_pkg;
    localparam int DATA_BITS = 8;

    localparam int CTRL_TX_EN         = 0;
    localparam int CTRL_TX_SENDING    = 1;
    localparam int CTRL_RX_HAS_DATA   = 2;
    localparam int CTRL_RX_OVERRUN    = 3;
    localparam int CTRL_RX_FRAME_ERR  = 4;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
endpackage

// File: rtl/uart_transceiver_if.sv
// Command-FSM side bundle of the UART: serial pins, TX load/control strobes, RX byte and status.
interface uart_transceiver_if;
    import uart_pkg::*;

    logic                 uart_rxd;
    logic                 uart_txd;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_reg_en;
    logic                 uart_tx_en;
    logic                 ctrl_reg_en;
    logic                 tx_reset;
    logic                 rx_reset;
    logic [DATA_BITS-1:0] rx_data;
    logic [7:0]           uart_ctrl_out;

    modport master (
        output uart_rxd, tx_data, tx_reg_en, uart_tx_en, ctrl_reg_en, tx_reset, rx_reset,
        input  uart_txd, rx_data, uart_ctrl_out
    );

    modport slave (
        input  uart_rxd, tx_data, tx_reg_en, uart_tx_en, ctrl_reg_en, tx_reset, rx_reset,
        output uart_txd, rx_data, uart_ctrl_out
    );
endinterface

// File: rtl/register.sv
// Generic enabled register with asynchronous active-high reset to RST_VAL.
// Latency 1 cycle; no backpressure.
module register #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     o_q <= RST_VAL;
        else if (i_en) o_q <= i_d;
    end
endmodule

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
// A load of value V gives a terminal count V+1 cycles later; no backpressure.
module uart_bit_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)              r_cnt <= '0;
        else if (i_load)        r_cnt <= i_load_val;
        else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
    end

    assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: RX byte lands 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge;
// TX line falls 1 cycle after TX_EN is seen in idle. No backpressure: an unread RX byte blocks later ones (overrun).
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    uart_transceiver_if.slave bus
);
    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- receiver ----------------
    logic                 r_rxd_s1, r_rxd_s2, r_rxd_prev;
    rx_state_t            r_rx_state, w_rx_next;
    logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
    logic [2:0]           r_rx_bit;
    logic                 r_rx_brk;
    logic [2:0]           r_rx_flags, w_rx_flags_nxt;   // {frame_err, overrun, has_data}
    logic                 w_rx_tc, w_rx_tload, w_rx_fall, w_rx_stop_ok, w_rx_stop_bad, w_rx_take;
    logic [TW-1:0]        w_rx_tval;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) {r_rxd_s1, r_rxd_s2, r_rxd_prev} <= 3'b111;
        else       {r_rxd_s1, r_rxd_s2, r_rxd_prev} <= {bus.uart_rxd, r_rxd_s1, r_rxd_s2};
    end

    assign w_rx_fall  = r_rxd_prev & ~r_rxd_s2;
    assign w_rx_tload = (r_rx_state == R_IDLE) || w_rx_tc;
    assign w_rx_tval  = (r_rx_state == R_IDLE) ? HALF_LOAD : BIT_LOAD;

    uart_bit_timer #(.W(TW)) u_rx_timer (
        .i_clk(clk), .i_rst(reset), .i_load(w_rx_tload), .i_load_val(w_rx_tval), .o_tc(w_rx_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rx_state <= R_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        if (bus.rx_reset) begin
            w_rx_next = R_IDLE;
        end else begin
            case (r_rx_state)
                R_IDLE:  if (w_rx_fall) w_rx_next = R_START;
                R_START: if (w_rx_tc)   w_rx_next = r_rxd_s2 ? R_IDLE : R_DATA;
                R_DATA:  if (w_rx_tc && r_rx_bit == 3'(DATA_BITS - 1)) w_rx_next = R_STOP;
                // after a bad stop bit, hold here until the line recovers
                R_STOP:  if (r_rx_brk ? r_rxd_s2 : (w_rx_tc && r_rxd_s2)) w_rx_next = R_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rx_stop_ok  = (r_rx_state == R_STOP) && !r_rx_brk && w_rx_tc &&  r_rxd_s2;
        w_rx_stop_bad = (r_rx_state == R_STOP) && !r_rx_brk && w_rx_tc && !r_rxd_s2;
        w_rx_take     = w_rx_stop_ok && !r_rx_flags[0] && !bus.rx_reset;
        w_rx_flags_nxt = bus.rx_reset ? 3'b000 :
                         {r_rx_flags[2] | w_rx_stop_bad,
                          r_rx_flags[1] | (w_rx_stop_ok & r_rx_flags[0]),
                          r_rx_flags[0] | w_rx_stop_ok};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
            r_rx_brk   <= 1'b0;
        end else begin
            if (r_rx_state == R_START) r_rx_bit <= '0;
            if (r_rx_state == R_DATA && w_rx_tc) begin
                r_rx_shift <= {r_rxd_s2, r_rx_shift[DATA_BITS-1:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if (bus.rx_reset || r_rx_state != R_STOP) r_rx_brk <= 1'b0;
            else if (w_rx_stop_bad)                   r_rx_brk <= 1'b1;
        end
    end

    register #(.W(3))         u_rx_flags (.i_clk(clk), .i_rst(reset), .i_en(1'b1),
                                           .i_d(w_rx_flags_nxt), .o_q(r_rx_flags));
    register #(.W(DATA_BITS)) u_rx_data  (.i_clk(clk), .i_rst(reset), .i_en(w_rx_take),
                                           .i_d(r_rx_shift), .o_q(r_rx_data));

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state, w_tx_next;
    logic [DATA_BITS-1:0] r_tx_hold, r_tx_shift;
    logic [2:0]           r_tx_bit;
    logic                 r_tx_en, w_tx_en_nxt;
    logic                 w_tx_tc, w_tx_start, w_tx_done, w_txd, w_tx_sending;

    register #(.W(DATA_BITS)) u_tx_hold (.i_clk(clk), .i_rst(reset), .i_en(bus.tx_reg_en),
                                          .i_d(bus.tx_data), .o_q(r_tx_hold));
    register #(.W(1))         u_tx_en   (.i_clk(clk), .i_rst(reset), .i_en(1'b1),
                                          .i_d(w_tx_en_nxt), .o_q(r_tx_en));

    uart_bit_timer #(.W(TW)) u_tx_timer (
        .i_clk(clk), .i_rst(reset), .i_load((r_tx_state == T_IDLE) || w_tx_tc),
        .i_load_val(BIT_LOAD), .o_tc(w_tx_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tx_state <= T_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        if (bus.tx_reset) begin
            w_tx_next = T_IDLE;
        end else begin
            case (r_tx_state)
                T_IDLE:  if (r_tx_en) w_tx_next = T_START;
                T_START: if (w_tx_tc) w_tx_next = T_DATA;
                T_DATA:  if (w_tx_tc && r_tx_bit == 3'(DATA_BITS - 1)) w_tx_next = T_STOP;
                T_STOP:  if (w_tx_tc) w_tx_next = T_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tx_start   = (r_tx_state == T_IDLE) && r_tx_en && !bus.tx_reset;
        w_tx_done    = (r_tx_state == T_STOP) && w_tx_tc;
        w_tx_sending = (r_tx_state != T_IDLE);
        w_txd        = 1'b1;
        if (r_tx_state == T_START)     w_txd = 1'b0;
        else if (r_tx_state == T_DATA) w_txd = r_tx_shift[0];
    end

    // a write of 1 mid-frame changes nothing; a write of 0 mid-frame lets the frame finish
    always_comb begin
        w_tx_en_nxt = r_tx_en;
        if (bus.tx_reset)
            w_tx_en_nxt = bus.ctrl_reg_en & bus.uart_tx_en;
        else if (w_tx_done)
            w_tx_en_nxt = 1'b0;
        else if (bus.ctrl_reg_en && (r_tx_state == T_IDLE || !bus.uart_tx_en))
            w_tx_en_nxt = bus.uart_tx_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
        end else if (w_tx_start) begin
            r_tx_shift <= r_tx_hold;
            r_tx_bit   <= '0;
        end else if (r_tx_state == T_DATA && w_tx_tc) begin
            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.uart_ctrl_out                    = '0;
        bus.uart_ctrl_out[CTRL_TX_EN]        = r_tx_en;
        bus.uart_ctrl_out[CTRL_TX_SENDING]   = w_tx_sending;
        bus.uart_ctrl_out[CTRL_RX_HAS_DATA]  = r_rx_flags[0];
        bus.uart_ctrl_out[CTRL_RX_OVERRUN]   = r_rx_flags[1];
        bus.uart_ctrl_out[CTRL_RX_FRAME_ERR] = r_rx_flags[2];
    end

    assign bus.uart_txd = w_txd;
    assign bus.rx_data  = r_rx_data;
endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver at CLKS_PER_BIT=4: directed TX/RX frames, monitors decode the outputs.
module tb_uart_transceiver;
    import uart_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    uart_transceiver_if bus();

    uart_transceiver #(.CLKS_PER_BIT(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { logic [7:0] b; bit aborted; } tx_exp_t;
    typedef struct { logic [7:0] data; logic [7:0] ctrl; } rx_exp_t;
    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    // TX monitor: decodes frames off uart_txd, sampling mid-bit
    logic       mon_prev_txd = 1'b1;
    bit         mon_in = 1'b0;
    int         mon_c = 0;
    logic [9:0] mon_bits;
    bit         mon_abort_seen = 1'b0;
    int         mon_abort_cyc = 0;
    bit         mon_done;
    tx_exp_t    te;

    always @(negedge clk) begin
        if (reset) begin
            mon_in       = 1'b0;
            mon_prev_txd = 1'b1;
        end else begin
            if (!mon_in && mon_prev_txd && !bus.uart_txd) begin
                mon_in   = 1'b1;
                mon_c    = 0;
                mon_bits = '0;
                if (mon_abort_seen) begin
                    check("tx_restart_latency", cyc - mon_abort_cyc, 1);
                    mon_abort_seen = 1'b0;
                end
            end
            if (mon_in) begin
                mon_done = 1'b0;
                if (mon_c < 10*N && bus.uart_ctrl_out[1]) begin
                    if (mon_c % N == N/2) mon_bits[mon_c / N] = bus.uart_txd;
                    mon_c++;
                end else begin
                    mon_done = 1'b1;
                end
                if (mon_done) begin
                    mon_in = 1'b0;
                    check("tx_expected_pending", int'(tx_q.size() > 0), 1);
                    if (tx_q.size() > 0) begin
                        te = tx_q.pop_front();
                        check("tx_frame_aborted", int'(mon_c < 10*N), int'(te.aborted));
                        if (te.aborted) begin
                            check("tx_abort_line_high", bus.uart_txd, 1);
                            mon_abort_seen = 1'b1;
                            mon_abort_cyc  = cyc;
                        end else begin
                            check("tx_byte", mon_bits[8:1], te.b);
                            check("tx_start_stop", {mon_bits[9], mon_bits[0]}, 2'b10);
                            check("tx_ctrl_after_frame", bus.uart_ctrl_out[1:0], 0);
                        end
                    end
                end
            end
            mon_prev_txd = bus.uart_txd;
        end
    end

    // RX monitor: any change of the RX flags is an event to score
    logic [2:0] rxm_prev = 3'b000;
    rx_exp_t    re;

    always @(negedge clk) begin
        if (reset) begin
            rxm_prev = 3'b000;
        end else if (bus.uart_ctrl_out[4:2] != rxm_prev) begin
            rxm_prev = bus.uart_ctrl_out[4:2];
            check("rx_expected_pending", int'(rx_q.size() > 0), 1);
            if (rx_q.size() > 0) begin
                re = rx_q.pop_front();
                check("rx_data", bus.rx_data, re.data);
                check("rx_ctrl", bus.uart_ctrl_out, re.ctrl);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_go(input logic [7:0] b);
        bus.tx_data = b; bus.tx_reg_en = 1'b1; bus.ctrl_reg_en = 1'b1; bus.uart_tx_en = 1'b1;
        tick();
        bus.tx_reg_en = 1'b0; bus.ctrl_reg_en = 1'b0; bus.uart_tx_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        bus.uart_rxd = 1'b0;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rxd = b[i];
            tick(N);
        end
        bus.uart_rxd = stop_bit;
        tick(N);
        bus.uart_rxd = 1'b1;
        tick(2*N);
    endtask

    task automatic rx_clear();
        bus.rx_reset = 1'b1;
        tick();
        bus.rx_reset = 1'b0;
    endtask

    initial begin
        bus.uart_rxd = 1'b1; bus.tx_data = '0; bus.tx_reg_en = 1'b0; bus.uart_tx_en = 1'b0;
        bus.ctrl_reg_en = 1'b0; bus.tx_reset = 1'b0; bus.rx_reset = 1'b0;

        tick(3);
        @(negedge clk);
        check("rst_txd", bus.uart_txd, 1);
        check("rst_ctrl", bus.uart_ctrl_out, 8'h00);
        check("rst_rx_data", bus.rx_data, 8'h00);
        tick();
        reset = 1'b0;
        tick(5);

        // TX 0xA5; mid-frame reload of holding reg and TX_EN=1 write must not disturb it
        tx_q.push_back('{8'hA5, 1'b0});
        tx_go(8'hA5);
        tick(10);
        bus.tx_data = 8'h5A; bus.tx_reg_en = 1'b1; bus.ctrl_reg_en = 1'b1; bus.uart_tx_en = 1'b1;
        tick();
        bus.tx_reg_en = 1'b0; bus.ctrl_reg_en = 1'b0; bus.uart_tx_en = 1'b0;
        tick(40);

        // held 0x5A goes out; TX_EN=0 written mid-frame lets it finish
        tx_q.push_back('{8'h5A, 1'b0});
        bus.ctrl_reg_en = 1'b1; bus.uart_tx_en = 1'b1;
        tick();
        bus.ctrl_reg_en = 1'b0; bus.uart_tx_en = 1'b0;
        tick(15);
        bus.ctrl_reg_en = 1'b1; bus.uart_tx_en = 1'b0;
        tick();
        bus.ctrl_reg_en = 1'b0;
        tick(40);

        // RX 0x15, then clear
        rx_q.push_back('{8'h15, 8'h04});
        send_rx(8'h15, 1'b1);
        tick(5);
        rx_q.push_back('{8'h15, 8'h00});
        rx_clear();
        tick(5);

        // reset in the middle of a TX and an RX frame
        tx_go(8'h81);
        tick(2);
        bus.uart_rxd = 1'b0;
        tick(12);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_txd", bus.uart_txd, 1);
        check("midrst_ctrl", bus.uart_ctrl_out, 8'h00);
        check("midrst_rx_data", bus.rx_data, 8'h00);
        bus.uart_rxd = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);

        // 0xA5 then 0x20 without clearing: overrun, rx_data keeps 0xA5
        rx_q.push_back('{8'hA5, 8'h04});
        send_rx(8'hA5, 1'b1);
        tick(4);
        rx_q.push_back('{8'hA5, 8'h0C});
        send_rx(8'h20, 1'b1);
        tick(5);
        rx_q.push_back('{8'hA5, 8'h00});
        rx_clear();
        tick(5);

        // bad stop bit, then a 1-cycle glitch that must raise nothing
        rx_q.push_back('{8'hA5, 8'h10});
        send_rx(8'h33, 1'b0);
        tick(10);
        bus.uart_rxd = 1'b0;
        tick();
        bus.uart_rxd = 1'b1;
        tick(20);
        @(negedge clk);
        check("glitch_ctrl", bus.uart_ctrl_out, 8'h10);
        tick();
        rx_q.push_back('{8'hA5, 8'h00});
        rx_clear();
        tick(5);

        // abort 0xC3 mid-frame with simultaneous reload of 0x3C and TX_EN=1
        tx_q.push_back('{8'hC3, 1'b1});
        tx_q.push_back('{8'h3C, 1'b0});
        tx_go(8'hC3);
        tick(15);
        bus.tx_reset = 1'b1; bus.uart_tx_en = 1'b1; bus.ctrl_reg_en = 1'b1;
        bus.tx_reg_en = 1'b1; bus.tx_data = 8'h3C;
        tick();
        bus.tx_reset = 1'b0; bus.uart_tx_en = 1'b0; bus.ctrl_reg_en = 1'b0; bus.tx_reg_en = 1'b0;
        tick(50);

        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
